mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin arbiter that shares one 8-bit output channel among three requesters (alpha, beta, gamma). It drives the 2-bit select and chip-select of the 3:1 output selector, gates its output, and runs a valid/ready handshake with the downstream consumer. Grants last a bounded burst so no requester can starve the others.

## Interface
- MAX_BURST, 4, max beats per grant before forced rotation (≥1)
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- req  input  3  request per source; bit 0 alpha, 1 beta, 2 gamma
- alpha, beta, gamma  input  8 each  source data
- out_ready  input  1  downstream accepts a beat
- gnt  output  3  one-hot grant, registered
- ack  output  3  one-hot; beat from source i transferred this cycle
- sel  output  2  select code: 0 alpha, 1 beta, 2 gamma
- cs  output  1  chip select; high while any grant is held
- out  output  8  selected data; 0 when cs=0
- out_valid  output  1  cs && req[sel]

## Operation
- FSM states IDLE, GRANT.
- IDLE: gnt=0, cs=0, sel=0. If req≠0, pick the first asserted bit in rotation order starting at ptr+1 (mod 3); go to GRANT next edge with gnt/sel set to the pick, beat_cnt=0.
- GRANT: out = data of sel source (combinational). Transfer = out_valid && out_ready; ack[sel]=transfer; beat_cnt += transfer.
- Grant release: (a) req[sel]=0 (abort; no transfer), or (b) transfer with beat_cnt==MAX_BURST-1. On release, ptr←sel; re-pick among current req from sel+1; if a pick exists, stay in GRANT with new grant next edge (no bubble), else IDLE.
- Current holder is eligible last in rotation: if it is the only requester after a burst-limit release, it is re-granted with beat_cnt=0.
- Sources hold data stable while req && !ack. Dropping req without ack is legal.
- out_ready low stalls indefinitely; grant held, beat_cnt unchanged, no timeout.
- beat_cnt width $clog2(MAX_BURST+1); never exceeds MAX_BURST-1.

## Timing
- Reset values: gnt=0, ack=0, sel=0, cs=0, out=0, out_valid=0, state=IDLE, ptr=2 (alpha wins first), beat_cnt=0.
- Latency req rise (IDLE) → gnt/cs: 1 cycle. Grant handover: 1 edge after release cycle, zero dead cycles.
- ack combinational in the transfer cycle; source may change data the cycle after.
- Simultaneous req all three: alpha, beta, gamma, alpha… per rotation.
- rst asserted mid-burst: next edge all outputs to reset values, ptr=2, burst discarded.
- MAX_BURST=1: rotation after every beat.

## Structure
- Package mux_arb_pkg: state_t enum {IDLE, GRANT}; NUM_REQ=3; SEL_ALPHA=2'd0, SEL_BETA=2'd1, SEL_GAMMA=2'd2; DATA_W=8.
- Sub-module rr_pick: combinational; inputs req[2:0], ptr[1:0]; outputs found, idx[1:0]. Used for IDLE pick and release re-pick.
- Top holds FSM, ptr, beat_cnt, gnt/sel/cs registers, output gating.

## Test plan
- Reset then req=3'b001, alpha=8'hA5, out_ready=1 → cycle+1 gnt=001, sel=0, cs=1, out=A5, ack=001 each cycle; 4 beats then re-grant alpha with beat_cnt=0.
- req=3'b111 held, out_ready=1, MAX_BURST=4 → 4 acks alpha, 4 beta, 4 gamma, repeat; no idle cycle between grants.
- Beta granted, out_ready=0 for 10 cycles with req=3'b111 → gnt=010, ack=0, out_valid=1 throughout; first ack on ready return.
- Gamma granted, drop req[2] after 2 beats while req[0]=1 → next edge gnt=001, sel=0; gamma burst discarded.
- rst pulsed mid-burst on beta → next edge gnt=0, cs=0, out=0; with req=3'b110 afterwards, beta granted first (ptr=2 → search alpha, beta).
- MAX_BURST=1, req=3'b101 → grants alternate alpha, gamma per beat; out=0 whenever cs=0.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the three-source round-robin output arbiter.
package mux_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 8;

  localparam logic [1:0] SEL_ALPHA = 2'd0;
  localparam logic [1:0] SEL_BETA  = 2'd1;
  localparam logic [1:0] SEL_GAMMA = 2'd2;

  // One-hot grant vector for a select code; unused code 3 maps to no grant.
  function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [1:0] s);
    case (s)
      SEL_ALPHA: return 3'b001;
      SEL_BETA:  return 3'b010;
      SEL_GAMMA: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating priority picker: searches ptr+1, ptr+2, ptr (mod 3), so the
// source named by ptr is always considered last.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic               found,
  output logic [1:0]         idx
);

  logic [1:0] cand;

  // First asserted request in rotation order after ptr.
  always_comb begin
    found = 1'b0;
    idx   = SEL_ALPHA;
    cand  = SEL_ALPHA;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 2'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 8-bit output channel among alpha, beta and
// gamma, with bounded bursts and a valid/ready handshake downstream.
//
// Handshake: a beat transfers in any cycle where out_valid && out_ready are
// both high; out_valid is high whenever a grant is held and the holder still
// requests. ack reports that transfer combinationally, one-hot per source.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [DATA_W-1:0]   alpha,
  input  logic [DATA_W-1:0]   beta,
  input  logic [DATA_W-1:0]   gamma,
  input  logic                out_ready,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [NUM_REQ-1:0]  ack,
  output logic [1:0]          sel,
  output logic                cs,
  output logic [DATA_W-1:0]   out,
  output logic                out_valid,
  output state_t              dbg_state
);

  localparam int              CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t             state, state_n;
  logic [1:0]         ptr, ptr_n;
  logic [CNT_W-1:0]   beat_cnt, cnt_n;
  logic [1:0]         sel_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic               cs_n;

  logic               req_sel;
  logic [DATA_W-1:0]  data_sel;
  logic               transfer;
  logic               rel;
  logic [1:0]         pick_from;
  logic               pick_found;
  logic [1:0]         pick_idx;

  // Route the selected source's request and data.
  always_comb begin
    req_sel  = 1'b0;
    data_sel = '0;
    case (sel)
      SEL_ALPHA: begin req_sel = req[0]; data_sel = alpha; end
      SEL_BETA:  begin req_sel = req[1]; data_sel = beta;  end
      SEL_GAMMA: begin req_sel = req[2]; data_sel = gamma; end
      default:   begin req_sel = 1'b0;   data_sel = '0;    end
    endcase
  end

  assign out_valid = cs & req_sel;
  assign transfer  = out_valid & out_ready;
  assign ack       = transfer ? sel_onehot(sel) : '0;
  assign out       = cs ? data_sel : '0;
  assign dbg_state = state;

  // A grant ends when its holder withdraws or its last allowed beat moves.
  assign rel = (state == GRANT) &&
               (!req_sel || (transfer && (beat_cnt == LAST_BEAT)));

  // From IDLE the search starts after ptr; on release it starts after the
  // holder, which is the value ptr takes at that edge anyway.
  assign pick_from = (state == GRANT) ? sel : ptr;

  rr_pick u_pick (
    .req   (req),
    .ptr   (pick_from),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state, grant and burst-counter decisions.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = beat_cnt;
    sel_n   = sel;
    gnt_n   = gnt;
    cs_n    = cs;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = GRANT;
          sel_n   = pick_idx;
          gnt_n   = sel_onehot(pick_idx);
          cs_n    = 1'b1;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_n = sel;
          cnt_n = '0;
          if (pick_found) begin
            sel_n = pick_idx;
            gnt_n = sel_onehot(pick_idx);
            cs_n  = 1'b1;
          end else begin
            state_n = IDLE;
            sel_n   = SEL_ALPHA;
            gnt_n   = '0;
            cs_n    = 1'b0;
          end
        end else if (transfer) begin
          cnt_n = beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        sel_n   = SEL_ALPHA;
        gnt_n   = '0;
        cs_n    = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

  // State registers; ptr resets to gamma so alpha wins the first pick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= SEL_GAMMA;
      beat_cnt <= '0;
      sel      <= SEL_ALPHA;
      gnt      <= '0;
      cs       <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      beat_cnt <= cnt_n;
      sel      <= sel_n;
      gnt      <= gnt_n;
      cs       <= cs_n;
    end
  end

endmodule
